pt_sb_msg_arbiter: RTL and testbench

- Shares the single sideband (SB) transmit port between two point-test requesters: the TX-side partner and the RX-side partner of the D2C point test.
- Grants one requester at a time, round-robin. Latches the granted encoded message and presents it to the SB.
- Tracks the SB busy handshake and returns a one-cycle falling-edge-busy pulse to the granted requester.
- Gives each requester an "other side is sending" indication so a response can be held back and re-issued after the other side finishes.

---
 rtl/pt_sb_pkg.sv | 26 ++
 rtl/pt_sb_rr_picker.sv | 29 ++
 rtl/pt_sb_msg_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_pt_sb_msg_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_sb_pkg.sv
// rtl/pt_sb_pkg.sv - shared SB message codes, arbiter states and requester IDs for the D2C point test
package pt_sb_pkg;

    // Encoded SB message codes shared by both point-test blocks and the arbiter
    localparam logic [3:0] SB_START_REQ            = 4'd1;
    localparam logic [3:0] SB_START_RESP           = 4'd2;
    localparam logic [3:0] SB_LFSR_CLR_ERROR_REQ   = 4'd3;
    localparam logic [3:0] SB_LFSR_CLR_ERROR_RESP  = 4'd4;
    localparam logic [3:0] SB_COUNT_DONE_REQ       = 4'd5;
    localparam logic [3:0] SB_COUNT_DONE_RESP      = 4'd6;
    localparam logic [3:0] SB_END_REQ              = 4'd7;
    localparam logic [3:0] SB_END_RESP             = 4'd8;

    // Requester IDs
    localparam logic REQ_TX = 1'b0;
    localparam logic REQ_RX = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_ABORT     = 3'd4
    } arb_state_e;

endpackage

// File: rtl/pt_sb_rr_picker.sv
// rtl/pt_sb_rr_picker.sv - combinational 2-way round-robin select between TX and RX requesters
// Ports:
//   valid_tx_i, valid_rx_i  request lines
//   last_grant_i            requester granted most recently (REQ_TX/REQ_RX)
//   grant_o                 selected requester
//   any_o                   at least one request present
module pt_sb_rr_picker
    import pt_sb_pkg::*;
(
    input  logic valid_tx_i,
    input  logic valid_rx_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic any_o
);

    assign any_o = valid_tx_i | valid_rx_i;

    always_comb begin
        grant_o = REQ_TX;
        if (valid_tx_i && valid_rx_i) begin
            // Contention: the side that did not go last wins
            grant_o = ~last_grant_i;
        end else if (valid_rx_i) begin
            grant_o = REQ_RX;
        end
    end

endmodule

// File: rtl/pt_sb_msg_arbiter.sv
// rtl/pt_sb_msg_arbiter.sv - round-robin sharing of the SB transmit port between point-test TX and RX partners
// Optional watchdog: define PT_SB_ARB_TIMEOUT_EN.
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_arb_en                          enable; low returns to IDLE and clears outputs
//   i_valid_tx, i_encoded_SB_msg_tx   TX-side request and message code
//   i_valid_rx, i_encoded_SB_msg_rx   RX-side request and message code
//   i_SB_Busy                         SB serializer busy
//   o_sb_valid, o_encoded_SB_msg      granted message to the SB
//   o_falling_edge_busy_tx/_rx        one-cycle done pulse to the granted side
//   o_tx_sending, o_rx_sending        side currently holding the SB port
//   o_timeout                         sticky watchdog flag (0 without the watchdog)
module pt_sb_msg_arbiter
    import pt_sb_pkg::*;
#(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_arb_en,
    input  logic                    i_valid_tx,
    input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_tx,
    input  logic                    i_valid_rx,
    input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_rx,
    input  logic                    i_SB_Busy,
    output logic                    o_sb_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
    output logic                    o_falling_edge_busy_tx,
    output logic                    o_falling_edge_busy_rx,
    output logic                    o_tx_sending,
    output logic                    o_rx_sending,
    output logic                    o_timeout
);

    arb_state_e              state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    busy_q;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
    logic                    sb_valid_q, sb_valid_d;
    logic                    tx_sending_q, tx_sending_d;
    logic                    rx_sending_q, rx_sending_d;
    logic                    fe_tx_q, fe_tx_d;
    logic                    fe_rx_q, fe_rx_d;

    logic pick_grant;
    logic pick_any;
    logic granted_valid;
    logic busy_fall;

    pt_sb_rr_picker u_picker (
        .valid_tx_i   (i_valid_tx),
        .valid_rx_i   (i_valid_rx),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_grant),
        .any_o        (pick_any)
    );

    assign busy_fall     = busy_q & ~i_SB_Busy;
    // Only the granted side's request line is watched once a grant is made
    assign granted_valid = (grant_q == REQ_TX) ? i_valid_tx : i_valid_rx;

`ifdef PT_SB_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    logic             tmo_hit;

    assign tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        msg_d        = msg_q;
        sb_valid_d   = sb_valid_q;
        tx_sending_d = tx_sending_q;
        rx_sending_d = rx_sending_q;
        fe_tx_d      = 1'b0;
        fe_rx_d      = 1'b0;
`ifdef PT_SB_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
`endif

        if (!i_arb_en) begin
            // Disable wins over everything; last_grant is kept so fairness survives
            state_d      = ST_IDLE;
            sb_valid_d   = 1'b0;
            tx_sending_d = 1'b0;
            rx_sending_d = 1'b0;
`ifdef PT_SB_ARB_TIMEOUT_EN
            tmo_cnt_d    = '0;
            timeout_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Never start a message while the serializer is still busy
                    if (!i_SB_Busy && pick_any) begin
                        grant_d      = pick_grant;
                        last_grant_d = pick_grant;
                        msg_d        = (pick_grant == REQ_TX) ? i_encoded_SB_msg_tx
                                                              : i_encoded_SB_msg_rx;
                        sb_valid_d   = 1'b1;
                        tx_sending_d = (pick_grant == REQ_TX);
                        rx_sending_d = (pick_grant == REQ_RX);
                        state_d      = ST_ISSUE;
`ifdef PT_SB_ARB_TIMEOUT_EN
                        tmo_cnt_d    = '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (i_SB_Busy) begin
                        state_d = ST_WAIT_DONE;
                    end else if (!granted_valid) begin
                        sb_valid_d   = 1'b0;
                        tx_sending_d = 1'b0;
                        rx_sending_d = 1'b0;
                        state_d      = ST_ABORT;
                    end
                end
                ST_WAIT_DONE: begin
                    if (busy_fall) begin
                        fe_tx_d    = (grant_q == REQ_TX);
                        fe_rx_d    = (grant_q == REQ_RX);
                        sb_valid_d = 1'b0;
                        state_d    = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Absorbs the requester's cycle to drop valid after its pulse
                    tx_sending_d = 1'b0;
                    rx_sending_d = 1'b0;
                    state_d      = ST_IDLE;
                end
                ST_ABORT: begin
                    sb_valid_d   = 1'b0;
                    tx_sending_d = 1'b0;
                    rx_sending_d = 1'b0;
                    state_d      = ST_IDLE;
                end
                default: begin
                    sb_valid_d   = 1'b0;
                    tx_sending_d = 1'b0;
                    rx_sending_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            endcase

`ifdef PT_SB_ARB_TIMEOUT_EN
            // Watchdog overrides normal progress: abort silently, no done pulse
            if (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) begin
                if (tmo_hit) begin
                    timeout_d    = 1'b1;
                    sb_valid_d   = 1'b0;
                    tx_sending_d = 1'b0;
                    rx_sending_d = 1'b0;
                    fe_tx_d      = 1'b0;
                    fe_rx_d      = 1'b0;
                    state_d      = ST_ABORT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_TX;
            last_grant_q <= REQ_RX;
            busy_q       <= 1'b0;
            msg_q        <= '0;
            sb_valid_q   <= 1'b0;
            tx_sending_q <= 1'b0;
            rx_sending_q <= 1'b0;
            fe_tx_q      <= 1'b0;
            fe_rx_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= i_SB_Busy;
            msg_q        <= msg_d;
            sb_valid_q   <= sb_valid_d;
            tx_sending_q <= tx_sending_d;
            rx_sending_q <= rx_sending_d;
            fe_tx_q      <= fe_tx_d;
            fe_rx_q      <= fe_rx_d;
        end
    end

`ifdef PT_SB_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign o_sb_valid             = sb_valid_q;
    assign o_encoded_SB_msg       = msg_q;
    assign o_falling_edge_busy_tx = fe_tx_q;
    assign o_falling_edge_busy_rx = fe_rx_q;
    assign o_tx_sending           = tx_sending_q;
    assign o_rx_sending           = rx_sending_q;

endmodule

// File: tb/tb_pt_sb_msg_arbiter.sv
// tb/tb_pt_sb_msg_arbiter.sv - directed and randomized self-checking bench for pt_sb_msg_arbiter
module tb_pt_sb_msg_arbiter;
    import pt_sb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arb_en;
    logic       vtx, vrx, busy;
    logic [3:0] mtx, mrx;
    logic       sb_valid;
    logic [3:0] msg;
    logic       fe_tx, fe_rx, tx_sending, rx_sending, timeout;

    int checks = 0;
    int errors = 0;

    logic       mdl_last;
    logic       inflight;
    logic       cur_side;
    logic [3:0] cur_msg;
    logic       exp_side;
    logic       dropped_tx, dropped_rx;
    int         sb_delay, sb_len;
    logic       sb_done;
    int         req_cnt [2];
    int         srv_cnt [2];

    always #5 clk = ~clk;

    pt_sb_msg_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_arb_en               (arb_en),
        .i_valid_tx             (vtx),
        .i_encoded_SB_msg_tx    (mtx),
        .i_valid_rx             (vrx),
        .i_encoded_SB_msg_rx    (mrx),
        .i_SB_Busy              (busy),
        .o_sb_valid             (sb_valid),
        .o_encoded_SB_msg       (msg),
        .o_falling_edge_busy_tx (fe_tx),
        .o_falling_edge_busy_rx (fe_rx),
        .o_tx_sending           (tx_sending),
        .o_rx_sending           (rx_sending),
        .o_timeout              (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, sb_valid, 1'b0);
        chk(tag, {tx_sending, rx_sending}, 2'b00);
        chk(tag, {fe_tx, fe_rx}, 2'b00);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_quiet(tag);
        chk(tag, msg, 4'd0);
        chk(tag, timeout, 1'b0);
    endtask

    task automatic chk_grant(input string tag, input logic side, input logic [3:0] m);
        chk(tag, sb_valid, 1'b1);
        chk(tag, tx_sending, side == REQ_TX);
        chk(tag, rx_sending, side == REQ_RX);
        chk(tag, msg, m);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        arb_en = 1'b1;
        vtx = 1'b0; vrx = 1'b0; busy = 1'b0; mtx = 4'd0; mrx = 4'd0;
        tick();
        tick();
        chk_reset_vals("reset_hold");
        rst_n = 1'b1;
        tick();
        chk_quiet("reset_release");
    endtask

    task automatic xfer(input logic side, input logic [3:0] m, input int pre, input int len);
        for (int i = 0; i < pre + len; i++) begin
            if (i == pre) busy = 1'b1;
            tick();
            chk_grant("xfer_hold", side, m);
            chk("xfer_no_pulse", {fe_tx, fe_rx}, 2'b00);
        end
        busy = 1'b0;
        tick();
        chk("xfer_pulse_tx", fe_tx, side == REQ_TX);
        chk("xfer_pulse_rx", fe_rx, side == REQ_RX);
        chk("xfer_valid_drop", sb_valid, 1'b0);
        if (side == REQ_TX) vtx = 1'b0; else vrx = 1'b0;
        tick();
        chk_quiet("xfer_gap");
    endtask

    task automatic rnd_step(input bit gen);
        tick();
        dropped_tx = 1'b0;
        dropped_rx = 1'b0;
        if (!inflight && sb_valid) begin
            if (vtx && vrx) exp_side = ~mdl_last;
            else            exp_side = vrx ? REQ_RX : REQ_TX;
            chk_grant("rnd_grant", exp_side, (exp_side == REQ_TX) ? mtx : mrx);
            inflight = 1'b1;
            cur_side = exp_side;
            cur_msg  = (exp_side == REQ_TX) ? mtx : mrx;
            mdl_last = exp_side;
            sb_delay = int'($urandom_range(0, 3));
            sb_done  = 1'b0;
        end else if (inflight && (fe_tx || fe_rx)) begin
            chk("rnd_pulse_tx", fe_tx, cur_side == REQ_TX);
            chk("rnd_pulse_rx", fe_rx, cur_side == REQ_RX);
            srv_cnt[cur_side]++;
            inflight = 1'b0;
            if (cur_side == REQ_TX) begin vtx = 1'b0; dropped_tx = 1'b1; end
            else                    begin vrx = 1'b0; dropped_rx = 1'b1; end
        end else begin
            chk("rnd_no_pulse", {fe_tx, fe_rx}, 2'b00);
            if (inflight) begin
                chk("rnd_valid_hold", sb_valid, 1'b1);
                chk("rnd_msg_hold", msg, cur_msg);
            end
        end
        chk("rnd_excl", tx_sending & rx_sending, 1'b0);

        if (gen && !vtx && !dropped_tx && $urandom_range(0, 3) == 0) begin
            vtx = 1'b1; mtx = 4'($urandom_range(1, 8)); req_cnt[0]++;
        end
        if (gen && !vrx && !dropped_rx && $urandom_range(0, 3) == 0) begin
            vrx = 1'b1; mrx = 4'($urandom_range(1, 8)); req_cnt[1]++;
        end

        if (inflight && !sb_done) begin
            if (sb_delay > 0) begin
                sb_delay--;
            end else if (!busy) begin
                busy   = 1'b1;
                sb_len = int'($urandom_range(1, 6));
            end else begin
                sb_len--;
                if (sb_len == 0) begin
                    busy    = 1'b0;
                    sb_done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic side;
        do_reset();

        vrx = 1'b1; mrx = SB_START_RESP;
        tick();
        chk_grant("t1_grant", REQ_RX, SB_START_RESP);
        xfer(REQ_RX, SB_START_RESP, 2, 5);

        do_reset();
        vtx = 1'b1; mtx = SB_START_REQ;
        vrx = 1'b1; mrx = SB_LFSR_CLR_ERROR_RESP;
        tick();
        side = REQ_TX;
        chk_grant("t2_first_tx", side, SB_START_REQ);
        for (int i = 0; i < 4; i++) begin
            xfer(side, (side == REQ_TX) ? mtx : mrx, 0, 2);
            if (side == REQ_TX) begin vtx = 1'b1; mtx = 4'(5 + i); end
            else                begin vrx = 1'b1; mrx = 4'(5 + i); end
            tick();
            side = ~side;
            chk_grant("t3_alternate", side, (side == REQ_TX) ? mtx : mrx);
        end
        xfer(side, (side == REQ_TX) ? mtx : mrx, 0, 1);
        vtx = 1'b0; vrx = 1'b0;
        tick();
        chk_quiet("t3_drained");

        vrx = 1'b1; mrx = SB_COUNT_DONE_RESP;
        tick();
        chk_grant("t4_grant", REQ_RX, SB_COUNT_DONE_RESP);
        vrx = 1'b0;
        tick();
        chk_quiet("t4_abort");
        tick();
        chk_quiet("t4_idle");
        vtx = 1'b1; mtx = SB_LFSR_CLR_ERROR_REQ;
        tick();
        chk_grant("t4_tx_after", REQ_TX, SB_LFSR_CLR_ERROR_REQ);
        xfer(REQ_TX, SB_LFSR_CLR_ERROR_REQ, 1, 3);

        vrx = 1'b1; mrx = SB_END_RESP;
        tick();
        chk_grant("t5_grant", REQ_RX, SB_END_RESP);
        busy = 1'b1;
        tick();
        chk("t5_wait", sb_valid, 1'b1);
        arb_en = 1'b0;
        tick();
        chk_quiet("t5_disabled");
        busy = 1'b0;
        tick();
        chk_quiet("t5_busy_fall");
        vrx = 1'b0; arb_en = 1'b1;
        tick();
        chk_quiet("t5_reenabled");
        vtx = 1'b1; mtx = SB_START_REQ;
        vrx = 1'b1; mrx = SB_START_RESP;
        tick();
        chk_grant("t5_rr_kept", REQ_TX, SB_START_REQ);
        xfer(REQ_TX, SB_START_REQ, 0, 2);
        tick();
        chk_grant("t5_rx_next", REQ_RX, SB_START_RESP);
        xfer(REQ_RX, SB_START_RESP, 0, 1);

        busy = 1'b1; vtx = 1'b1; mtx = SB_END_REQ;
        tick();
        chk("t6_busy_block", sb_valid, 1'b0);
        tick();
        chk("t6_busy_block2", sb_valid, 1'b0);
        busy = 1'b0;
        tick();
        chk_grant("t6_grant", REQ_TX, SB_END_REQ);

        busy = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t7_async_reset");
        vtx = 1'b0; busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_quiet("t7_after_reset");

        mdl_last = REQ_RX;
        inflight = 1'b0;
        sb_done  = 1'b0;
        req_cnt[0] = 0; req_cnt[1] = 0;
        srv_cnt[0] = 0; srv_cnt[1] = 0;
        for (int n = 0; n < 800; n++) rnd_step(1'b1);
        for (int n = 0; n < 300 && (vtx || vrx || inflight); n++) rnd_step(1'b0);
        chk("rnd_drained", {vtx, vrx, inflight}, 3'b000);
        chk("rnd_served_tx", srv_cnt[0], req_cnt[0]);
        chk("rnd_served_rx", srv_cnt[1], req_cnt[1]);

`ifdef PT_SB_ARB_TIMEOUT_EN
        busy = 1'b0;
        tick();
        vtx = 1'b1; mtx = SB_END_REQ;
        tick();
        chk_grant("t8_grant", REQ_TX, SB_END_REQ);
        busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t8_no_pulse", {fe_tx, fe_rx}, 2'b00);
        end
        chk("t8_timeout", timeout, 1'b1);
        chk("t8_aborted", sb_valid, 1'b0);
        busy = 1'b0; vtx = 1'b0;
        tick();
        chk("t8_no_pulse_fall", {fe_tx, fe_rx}, 2'b00);
        chk("t8_sticky", timeout, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
